// File: rtl/range_sample_framer.sv
// rtl/range_sample_framer.sv - assembles little-endian words from a byte stream
// and sequences the go/finish pulses for the downstream range-finder.
module range_sample_framer #(
    parameter int WIDTH     = 16,
    parameter int MAX_WORDS = 255,
    localparam int BYTES    = WIDTH / 8,
    localparam int CW       = $clog2(MAX_WORDS + 1),
    localparam int IW       = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             start_cmd,
    input  logic             end_cmd,
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    output logic             finish,
    output logic [CW-1:0]    word_count,
    output logic             frame_error,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSEMBLE = 2'd1,
        DRAIN    = 2'd2,
        FINISH   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             go_q, go_d;
    logic             finish_q, finish_d;
    logic [CW-1:0]    word_count_q, word_count_d;
    logic             frame_error_q, frame_error_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] word_tmp;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            partial_q     <= '0;
            data_out_q    <= '0;
            go_q          <= 1'b0;
            finish_q      <= 1'b0;
            word_count_q  <= '0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            partial_q     <= partial_d;
            data_out_q    <= data_out_d;
            go_q          <= go_d;
            finish_q      <= finish_d;
            word_count_q  <= word_count_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        partial_d     = partial_q;
        data_out_d    = data_out_q;
        go_d          = 1'b0;
        finish_d      = 1'b0;
        word_count_d  = word_count_q;
        frame_error_d = frame_error_q;
        word_tmp      = partial_q;

        case (state_q)
            IDLE: begin
                if (start_cmd) begin
                    state_d       = ASSEMBLE;
                    word_count_d  = '0;
                    idx_d         = '0;
                    partial_d     = '0;
                    frame_error_d = 1'b0;
                end
            end

            ASSEMBLE: begin
                if (byte_valid) begin
                    word_tmp[{idx_q, 3'b000} +: 8] = byte_in;
                    partial_d = word_tmp;
                    if (idx_q == IW'(BYTES - 1)) begin
                        data_out_d   = word_tmp;
                        idx_d        = '0;
                        word_count_d = word_count_q + CW'(1);
                        go_d         = (word_count_q == '0);
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end

                // A full frame wins over a coincident end_cmd; the byte is always taken first.
                if (word_count_d == CW'(MAX_WORDS)) begin
                    state_d = DRAIN;
                end else if (end_cmd) begin
                    if (idx_d != '0) begin
                        frame_error_d = 1'b1;
                        idx_d         = '0;
                        partial_d     = '0;
                    end
                    if (word_count_d == '0) begin
                        frame_error_d = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                state_d = FINISH;
            end

            FINISH: begin
                finish_d = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign data_out    = data_out_q;
    assign go          = go_q;
    assign finish      = finish_q;
    assign word_count  = word_count_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;

endmodule

// File: doc/range_sample_framer.md
Name:
range_sample_framer

Overview:
- Upstream feeder for the range-finder stage.
- Takes a byte-wide sample stream from the chip's 8-bit input pins and assembles little-endian WIDTH-bit words.
- Presents each word, held stable, on data_out.
- Generates the go/finish control pulses the range-finder consumes, sequenced so finish can never coincide with go and never arrives before go.

Parameters:
- WIDTH, 16: sample word width in bits. Must be a multiple of 8 and at least 8. BYTES = WIDTH/8.
- MAX_WORDS, 255: words per frame before finish is auto-issued. Must be at least 1. CW = $clog2(MAX_WORDS+1).

Ports:
- clock  input  1  system clock, all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- byte_in  input  8  sample byte.
- byte_valid  input  1  byte_in is valid this cycle. No backpressure; every valid byte in ASSEMBLE is consumed.
- start_cmd  input  1  begin a frame.
- end_cmd  input  1  end the current frame.
- data_out  output  WIDTH  last completed word. Held between updates.
- go  output  1  one-cycle pulse with the first word of a frame.
- finish  output  1  one-cycle frame-end pulse.
- word_count  output  CW  words completed in the current or last frame.
- frame_error  output  1  sticky error flag. Cleared on start_cmd.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any time, including mid-frame):
  - state=IDLE; data_out=0, go=0, finish=0, word_count=0, frame_error=0, busy=0.
  - Byte index and partial buffer cleared.
- All outputs are registered. No combinational input-to-output paths.
- States: IDLE, ASSEMBLE, DRAIN, FINISH.
- IDLE:
  - byte_valid and end_cmd are ignored.
  - start_cmd -> ASSEMBLE. Same edge: word_count=0, byte index=0, frame_error=0.
- ASSEMBLE:
  - On byte_valid, byte_in is written to partial[8*idx +: 8] and idx increments (first byte = LSB).
  - When the byte at idx=BYTES-1 is accepted at edge t:
    - data_out <= assembled word, idx <= 0, word_count <= word_count+1, all at edge t.
    - go <= 1 at edge t if this is the frame's first word, so go is high for exactly the cycle after t, together with the new data_out.
  - start_cmd is ignored.
  - end_cmd at edge t, including when a byte or word completes at the same edge (the byte is accepted first):
    - If idx is nonzero after that byte: the partial word is discarded and frame_error <= 1.
    - If word_count after this edge is 0: frame_error <= 1 and go to IDLE. No go or finish is ever produced for this frame.
    - Otherwise go to DRAIN.
  - If word_count reaches MAX_WORDS at edge t: go to DRAIN. end_cmd at the same edge changes nothing further.
- DRAIN:
  - One cycle, then FINISH. byte_valid is ignored.
  - This guarantees at least 2 cycles between the last data_out/go update and finish.
- FINISH:
  - finish=1 for exactly this one cycle, then IDLE. byte_valid is ignored.
  - start_cmd in FINISH is ignored.
- go and finish are never high in the same cycle. finish always follows a go of the same frame.
- word_count and data_out hold their values in IDLE until the next start_cmd or reset.
- word_count never exceeds MAX_WORDS.

Test Plan:
- Basic frame: start_cmd; bytes 0x34,0x12,0xCD,0xAB; end_cmd one cycle after the last byte.
  -> data_out=0x1234 with go=1 for one cycle; then data_out=0xABCD with go=0; word_count=2; finish=1 exactly 2 cycles after the end_cmd edge; frame_error=0; then IDLE.
- Same-edge end: start_cmd; byte 0x01; then byte 0x02 together with end_cmd.
  -> data_out=0x0201 and go high in the cycle after that edge; finish high 2 cycles later, never overlapping go.
- Partial word: start_cmd; bytes 0x10,0x20,0x30, then end_cmd.
  -> data_out=0x2010; 0x30 discarded; frame_error=1; word_count=1; finish issued.
- Empty frame: start_cmd, then end_cmd with no bytes.
  -> go and finish never assert; frame_error=1; busy returns to 0; next start_cmd clears frame_error.
- Auto-finish with MAX_WORDS=3: start_cmd; 8 bytes 0x01..0x08.
  -> words 0x0201, 0x0403, 0x0605; finish 2 cycles after the third word; bytes 0x07,0x08 ignored; word_count=3.
- Mid-frame reset: start_cmd; byte 0xFF; assert reset asynchronously between edges.
  -> all outputs 0 immediately; after release, byte_valid is ignored until start_cmd.
